sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one 1W/1R 512x16 SRAM macro between NREQ requesters on a single clock.
- Independent round-robin arbitration for the write port (port 0) and the read port (port 1), so one write and one read complete per cycle.
- Clears the array after reset and forwards data when a write and a read hit the same address in the same cycle.
- Sits between the CPU-side memory clients and the SRAM macro; the macro's clk0 and clk1 both connect to this block's clk.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 9, address width (depth 512).
- CLEAR_ON_RESET, 1, 1 = write zeros to all words after reset; 0 = skip to RUN.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request valid.
- we  in  NREQ  1 = write, 0 = read.
- addr  in  NREQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- wdata  in  NREQ*DATA_WIDTH  packed write data.
- gnt  out  NREQ  request accepted this cycle (combinational, one-hot per port).
- rvalid  out  NREQ  read data valid for requester i (registered).
- rdata  out  DATA_WIDTH  shared read data, qualified by rvalid.
- init_done  out  1  array clear finished; requests accepted.
- sram_csb0  out  1  write-port chip select, active low.
- sram_addr0  out  ADDR_WIDTH  write address.
- sram_din0  out  DATA_WIDTH  write data.
- sram_csb1  out  1  read-port chip select, active low.
- sram_addr1  out  ADDR_WIDTH  read address.
- sram_dout1  in  DATA_WIDTH  read data from macro.

Behaviour:
- Reset values while rst is high: gnt=0, rvalid=0, init_done=0, sram_csb0=1, sram_csb1=1, both RR pointers=0, clear counter=0, state=INIT (RUN if CLEAR_ON_RESET=0).
- Reset asserted mid-operation aborts any in-flight read (no rvalid). On release the block re-enters INIT.
- States:
  - INIT: sram_csb0=0, sram_addr0=counter, sram_din0=0; counter increments each cycle. gnt=0, sram_csb1=1. After the write of address 511, go to RUN. init_done goes to 1 on the first RUN cycle, exactly 512 cycles after reset release.
  - RUN: remains in RUN until reset.
- Arbitration in RUN:
  - Write candidates are req&we; read candidates are req&~we.
  - Each port has its own round-robin pointer. Search starts at the pointer index; the first candidate found wins.
  - After a grant, the pointer becomes (winner+1) mod NREQ. With no grant, the pointer holds.
  - gnt = write winner OR read winner. A requester is granted at most once per cycle; a non-granted requester holds req and its inputs stable.
- Port drive:
  - Write granted: sram_csb0=0, with the winner's addr and wdata. Otherwise sram_csb0=1.
  - Read granted: sram_csb1=0, with the winner's addr. Otherwise sram_csb1=1.
- Read latency: a read granted in cycle N gives rvalid[i]=1 for exactly one cycle at N+1, with rdata=sram_dout1 at that time. Back-to-back reads give one result per cycle.
- Same-cycle collision: if a write and a read are granted to the same address in cycle N:
  - sram_csb1 stays 1 (the macro is not read).
  - The write data is registered, and at N+1 rdata equals that write data.
  - The bypass flag is registered and lasts one cycle.
- Write at N followed by read of the same address at N+1 needs no forwarding; the macro returns the new data.
- Addresses are used unmodified; there is no wrap-around or range check (the full 2^ADDR_WIDTH space is valid).

Decomposition:
- Package sram_ctrl_pkg holds:
  - state encoding (INIT, RUN);
  - SRAM geometry constants (default DATA_WIDTH/ADDR_WIDTH, depth);
  - the index-width function for NREQ.
- One sub-module, rr_arbiter (NREQ-wide request vector in, one-hot grant plus pointer update out), instanced twice: write port and read port.

Test Plan:
- Clear: release reset with CLEAR_ON_RESET=1 -> init_done rises at cycle 512; sram_csb0=0 for addresses 0..511 with din0=0; gnt=0 throughout. A later read of address 0x1FF returns 0x0000.
- Basic access: req0 write 0x0A5 <- 0xBEEF at N; req0 read 0x0A5 at N+1 -> gnt0 in both cycles; rvalid0=1 at N+2 with rdata=0xBEEF.
- Read contention: req0 and req1 both hold reads of 0x010 (=0x1111) and 0x020 (=0x2222) for 4 cycles -> grants alternate 0,1,0,1; rvalid follows one cycle later with the matching data.
- Parallel ports: req0 writes 0x003 <- 0x1234 while req1 reads 0x004 (=0x5678) in the same cycle -> both gnt=1; next cycle rvalid1=1, rdata=0x5678.
- Collision bypass: req0 writes 0x040 <- 0xCAFE and req1 reads 0x040 in the same cycle -> sram_csb1=1; next cycle rvalid1=1, rdata=0xCAFE.
- Reset mid-read/mid-INIT: assert rst the cycle after a read grant -> rvalid stays 0, init_done=0; after release, init restarts at address 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types, geometry and helpers for the SRAM port arbiter
package sram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_ADDR_WIDTH = 9;
    localparam int SRAM_DEPTH      = 1 << SRAM_ADDR_WIDTH;

    // Pointer width for an n-entry round-robin; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - client request bus and SRAM macro pins of the port arbiter
interface sram_port_arbiter_if #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0]            we;
    logic [NREQ*ADDR_WIDTH-1:0] addr;
    logic [NREQ*DATA_WIDTH-1:0] wdata;
    logic [NREQ-1:0]            gnt;
    logic [NREQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       init_done;
    logic                       sram_csb0;
    logic [ADDR_WIDTH-1:0]      sram_addr0;
    logic [DATA_WIDTH-1:0]      sram_din0;
    logic                       sram_csb1;
    logic [ADDR_WIDTH-1:0]      sram_addr1;
    logic [DATA_WIDTH-1:0]      sram_dout1;

    modport master (
        output req, we, addr, wdata, sram_dout1,
        input  gnt, rvalid, rdata, init_done,
        input  sram_csb0, sram_addr0, sram_din0, sram_csb1, sram_addr1
    );

    modport slave (
        input  req, we, addr, wdata, sram_dout1,
        output gnt, rvalid, rdata, init_done,
        output sram_csb0, sram_addr0, sram_din0, sram_csb1, sram_addr1
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr, with next-pointer
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   ptr_nxt
);
    logic found;

    // Outer loop walks priority order from ptr; the first requester hit wins.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && ((int'(ptr) + k) % NREQ) == i) begin
                    gnt[i]  = 1'b1;
                    found   = 1'b1;
                    ptr_nxt = (i == NREQ - 1) ? '0 : IW'(i + 1);
                end
            end
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares a 1W/1R SRAM between NREQ clients with clear and bypass
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int DATA_WIDTH     = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH     = SRAM_ADDR_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);
    localparam int IW = idx_width(NREQ);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [IW-1:0]         wr_ptr_q, wr_ptr_nxt;
    logic [IW-1:0]         rd_ptr_q, rd_ptr_nxt;
    logic                  run;
    logic [NREQ-1:0]       wr_cand, rd_cand, wr_gnt, rd_gnt;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_any, rd_any, collide;
    logic [NREQ-1:0]       rvalid_q;
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    // rst gates everything combinational so the macro stays deselected while held.
    assign run     = (state_q == ST_RUN) && !rst;
    assign wr_cand = run ? (bus.req & bus.we)  : '0;
    assign rd_cand = run ? (bus.req & ~bus.we) : '0;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_wr_arb (
        .req     (wr_cand),
        .ptr     (wr_ptr_q),
        .gnt     (wr_gnt),
        .ptr_nxt (wr_ptr_nxt)
    );

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rd_arb (
        .req     (rd_cand),
        .ptr     (rd_ptr_q),
        .gnt     (rd_gnt),
        .ptr_nxt (rd_ptr_nxt)
    );

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wr_gnt[i]) begin
                wr_addr = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_gnt[i]) begin
                rd_addr = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign wr_any  = |wr_gnt;
    assign rd_any  = |rd_gnt;
    assign collide = wr_any && rd_any && (wr_addr == rd_addr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        bus.sram_csb0  = 1'b1;
        bus.sram_addr0 = wr_addr;
        bus.sram_din0  = wr_data;
        bus.sram_csb1  = 1'b1;
        bus.sram_addr1 = rd_addr;
        if (state_q == ST_INIT && !rst) begin
            bus.sram_csb0  = 1'b0;
            bus.sram_addr0 = cnt_q;
            bus.sram_din0  = '0;
        end else if (wr_any) begin
            bus.sram_csb0 = 1'b0;
        end
        // A same-address read is served from the write data, so skip the macro read.
        if (rd_any && !collide) begin
            bus.sram_csb1 = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) begin
                state_q <= ST_INIT;
            end else begin
                state_q <= ST_RUN;
            end
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rvalid_q   <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_nxt;
            rd_ptr_q <= rd_ptr_nxt;
            rvalid_q <= rd_gnt;
            byp_q    <= collide;
            if (collide) begin
                byp_data_q <= wr_data;
            end
        end
    end

    assign bus.gnt       = wr_gnt | rd_gnt;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = byp_q ? byp_data_q : bus.sram_dout1;
    assign bus.init_done = run;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed checks of the SRAM port arbiter with a macro model
module tb_sram_port_arbiter;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [15:0] mem [512];

    sram_port_arbiter_if #(.NREQ(2), .DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

    sram_port_arbiter #(
        .NREQ(2), .DATA_WIDTH(16), .ADDR_WIDTH(9), .CLEAR_ON_RESET(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1W/1R macro: write on port 0, registered read on port 1.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'hDEAD;
            bus.sram_dout1 <= 16'hDEAD;
        end else begin
            if (!bus.sram_csb0) mem[bus.sram_addr0] <= bus.sram_din0;
            if (!bus.sram_csb1) bus.sram_dout1 <= mem[bus.sram_addr1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int i, input logic r, input logic w,
                       input logic [8:0] a, input logic [15:0] d);
        bus.req[i]              = r;
        bus.we[i]               = w;
        bus.addr[i*9 +: 9]      = a;
        bus.wdata[i*16 +: 16]   = d;
    endtask

    task automatic idle();
        bus.req = '0;
        bus.we  = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.req     = '0;
        bus.we      = '0;
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.req     = 2'b01;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_init_done", 32'(bus.init_done), 32'h0);
        chk("rst_csb0", 32'(bus.sram_csb0), 32'h1);
        chk("rst_csb1", 32'(bus.sram_csb1), 32'h1);
        idle();

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            #1;
            chk("clr_csb0", 32'(bus.sram_csb0), 32'h0);
            chk("clr_addr0", 32'(bus.sram_addr0), 32'(i));
            chk("clr_din0", 32'(bus.sram_din0), 32'h0);
            chk("clr_gnt", 32'(bus.gnt), 32'h0);
            chk("clr_init_done", 32'(bus.init_done), 32'h0);
            @(negedge clk);
        end
        #1;
        chk("init_done_at_512", 32'(bus.init_done), 32'h1);
        chk("run_csb0_idle", 32'(bus.sram_csb0), 32'h1);

        // read back a cleared word
        @(negedge clk); drv(0, 1'b1, 1'b0, 9'h1FF, 16'h0); #1;
        chk("rd1ff_gnt", 32'(bus.gnt), 32'h1);
        chk("rd1ff_csb1", 32'(bus.sram_csb1), 32'h0);
        chk("rd1ff_addr1", 32'(bus.sram_addr1), 32'h1FF);
        @(negedge clk); idle(); #1;
        chk("rd1ff_rvalid", 32'(bus.rvalid), 32'h1);
        chk("rd1ff_rdata", 32'(bus.rdata), 32'h0000);

        // basic write then read
        @(negedge clk); drv(0, 1'b1, 1'b1, 9'h0A5, 16'hBEEF); #1;
        chk("bw_gnt", 32'(bus.gnt), 32'h1);
        chk("bw_csb0", 32'(bus.sram_csb0), 32'h0);
        chk("bw_addr0", 32'(bus.sram_addr0), 32'h0A5);
        chk("bw_din0", 32'(bus.sram_din0), 32'hBEEF);
        chk("bw_csb1", 32'(bus.sram_csb1), 32'h1);
        @(negedge clk); drv(0, 1'b1, 1'b0, 9'h0A5, 16'h0); #1;
        chk("br_gnt", 32'(bus.gnt), 32'h1);
        chk("br_csb1", 32'(bus.sram_csb1), 32'h0);
        chk("br_rvalid_early", 32'(bus.rvalid), 32'h0);
        @(negedge clk); idle(); #1;
        chk("br_rvalid", 32'(bus.rvalid), 32'h1);
        chk("br_rdata", 32'(bus.rdata), 32'hBEEF);

        // preload
        @(negedge clk); drv(0, 1'b1, 1'b1, 9'h010, 16'h1111); #1;
        chk("pl010_gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk); drv(0, 1'b1, 1'b1, 9'h020, 16'h2222); #1;
        chk("pl020_gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk); drv(0, 1'b1, 1'b1, 9'h004, 16'h5678); #1;
        chk("pl004_gnt", 32'(bus.gnt), 32'h1);

        // parallel write and read
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 9'h003, 16'h1234);
        drv(1, 1'b1, 1'b0, 9'h004, 16'h0);
        #1;
        chk("par_gnt", 32'(bus.gnt), 32'h3);
        chk("par_csb0", 32'(bus.sram_csb0), 32'h0);
        chk("par_csb1", 32'(bus.sram_csb1), 32'h0);
        chk("par_addr0", 32'(bus.sram_addr0), 32'h003);
        chk("par_addr1", 32'(bus.sram_addr1), 32'h004);
        @(negedge clk); idle(); #1;
        chk("par_rvalid", 32'(bus.rvalid), 32'h2);
        chk("par_rdata", 32'(bus.rdata), 32'h5678);

        // read contention, read pointer now at 0
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 9'h010, 16'h0);
        drv(1, 1'b1, 1'b0, 9'h020, 16'h0);
        #1;
        chk("rc1_gnt", 32'(bus.gnt), 32'h1);
        chk("rc1_addr1", 32'(bus.sram_addr1), 32'h010);
        @(negedge clk); #1;
        chk("rc2_gnt", 32'(bus.gnt), 32'h2);
        chk("rc2_addr1", 32'(bus.sram_addr1), 32'h020);
        chk("rc2_rvalid", 32'(bus.rvalid), 32'h1);
        chk("rc2_rdata", 32'(bus.rdata), 32'h1111);
        @(negedge clk); #1;
        chk("rc3_gnt", 32'(bus.gnt), 32'h1);
        chk("rc3_rvalid", 32'(bus.rvalid), 32'h2);
        chk("rc3_rdata", 32'(bus.rdata), 32'h2222);
        @(negedge clk); #1;
        chk("rc4_gnt", 32'(bus.gnt), 32'h2);
        chk("rc4_rvalid", 32'(bus.rvalid), 32'h1);
        chk("rc4_rdata", 32'(bus.rdata), 32'h1111);
        @(negedge clk); idle(); #1;
        chk("rc5_gnt", 32'(bus.gnt), 32'h0);
        chk("rc5_rvalid", 32'(bus.rvalid), 32'h2);
        chk("rc5_rdata", 32'(bus.rdata), 32'h2222);

        // same-cycle collision forwards write data
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 9'h040, 16'hCAFE);
        drv(1, 1'b1, 1'b0, 9'h040, 16'h0);
        #1;
        chk("col_gnt", 32'(bus.gnt), 32'h3);
        chk("col_csb0", 32'(bus.sram_csb0), 32'h0);
        chk("col_csb1", 32'(bus.sram_csb1), 32'h1);
        @(negedge clk); idle(); #1;
        chk("col_rvalid", 32'(bus.rvalid), 32'h2);
        chk("col_rdata", 32'(bus.rdata), 32'hCAFE);
        @(negedge clk); drv(1, 1'b1, 1'b0, 9'h040, 16'h0); #1;
        chk("col_rb_gnt", 32'(bus.gnt), 32'h2);
        chk("col_rb_csb1", 32'(bus.sram_csb1), 32'h0);
        @(negedge clk); idle(); #1;
        chk("col_rb_rvalid", 32'(bus.rvalid), 32'h2);
        chk("col_rb_rdata", 32'(bus.rdata), 32'hCAFE);

        // reset while a read is in flight
        @(negedge clk); drv(0, 1'b1, 1'b0, 9'h0A5, 16'h0); #1;
        chk("rr_gnt", 32'(bus.gnt), 32'h1);
        #1; rst = 1'b1; #1;
        chk("rr_gnt_in_rst", 32'(bus.gnt), 32'h0);
        chk("rr_csb1_in_rst", 32'(bus.sram_csb1), 32'h1);
        chk("rr_csb0_in_rst", 32'(bus.sram_csb0), 32'h1);
        @(negedge clk); #1;
        chk("rr_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rr_init_done", 32'(bus.init_done), 32'h0);
        idle();
        @(negedge clk); rst = 1'b0; #1;
        chk("rr_restart_csb0", 32'(bus.sram_csb0), 32'h0);
        chk("rr_restart_addr0", 32'(bus.sram_addr0), 32'h0);
        @(negedge clk); #1;
        chk("rr_restart_addr1", 32'(bus.sram_addr0), 32'h1);
        chk("rr_restart_init", 32'(bus.init_done), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
